// File: rtl/seg7_capture_decode.sv
// Seven-segment capture/decode monitor: filters an active-low segment bus for stability and decodes it.
// Optional invalid-commit counter enabled by defining SEG7_ERR_CNT_EN.
module seg7_capture_decode #(
  parameter int STABLE_CYCLES = 4
`ifdef SEG7_ERR_CNT_EN
  , parameter int ERR_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       seg_in,
  input  logic             sample_en,
`ifdef SEG7_ERR_CNT_EN
  output logic [ERR_W-1:0] err_count,
`endif
  output logic [3:0]       bcd_out,
  output logic             dot_out,
  output logic             blank_out,
  output logic             invalid_out,
  output logic             update_pulse,
  output logic             locked
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t          state_q;
  logic [7:0]      cand_q;
  logic [7:0]      last_q;
  logic            last_vld_q;
  logic [CW-1:0]   cnt_q;

  logic            take_new_d;
  logic            settle_step_d;
  logic            commit_d;
  logic            pulse_d;
  logic [7:0]      pat_d;
  logic [CW-1:0]   cnt_inc_d;
  logic [3:0]      dec_bcd_d;
  logic            dec_blank_d;
  logic            dec_inv_d;

  // A new candidate is taken from IDLE or whenever the bus differs from the held candidate.
  always_comb begin
    take_new_d    = sample_en && ((state_q == IDLE) || (seg_in != cand_q));
    settle_step_d = sample_en && !take_new_d && (state_q == SETTLE);
    cnt_inc_d     = cnt_q + 1'b1;
    pat_d         = take_new_d ? seg_in : cand_q;
    commit_d      = 1'b0;
    if (take_new_d) begin
      commit_d = (STABLE_CYCLES == 1);
    end else if (settle_step_d) begin
      commit_d = (cnt_inc_d == STABLE_C);
    end
    pulse_d = commit_d && (!last_vld_q || (pat_d != last_q));
  end

  always_comb begin
    dec_bcd_d   = 4'hE;
    dec_blank_d = 1'b0;
    dec_inv_d   = 1'b0;
    case (pat_d[6:0])
      7'h40: dec_bcd_d = 4'd0;
      7'h79: dec_bcd_d = 4'd1;
      7'h24: dec_bcd_d = 4'd2;
      7'h30: dec_bcd_d = 4'd3;
      7'h19: dec_bcd_d = 4'd4;
      7'h12: dec_bcd_d = 4'd5;
      7'h02: dec_bcd_d = 4'd6;
      7'h78: dec_bcd_d = 4'd7;
      7'h00: dec_bcd_d = 4'd8;
      7'h18: dec_bcd_d = 4'd9;
      7'h7F: begin
        dec_bcd_d   = 4'hF;
        dec_blank_d = 1'b1;
      end
      default: dec_inv_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cand_q       <= 8'hFF;
      cnt_q        <= '0;
      last_q       <= 8'hFF;
      last_vld_q   <= 1'b0;
      bcd_out      <= 4'hF;
      dot_out      <= 1'b0;
      blank_out    <= 1'b1;
      invalid_out  <= 1'b0;
      update_pulse <= 1'b0;
      locked       <= 1'b0;
    end else begin
      update_pulse <= pulse_d;
      if (take_new_d) begin
        cand_q  <= seg_in;
        cnt_q   <= CW'(1);
        locked  <= 1'b0;
        state_q <= SETTLE;
      end else if (settle_step_d) begin
        cnt_q <= cnt_inc_d;
      end
      // Commit overrides the SETTLE transition and the locked clear above.
      if (commit_d) begin
        state_q     <= LOCKED;
        locked      <= 1'b1;
        bcd_out     <= dec_bcd_d;
        dot_out     <= ~pat_d[7];
        blank_out   <= dec_blank_d;
        invalid_out <= dec_inv_d;
        last_q      <= pat_d;
        last_vld_q  <= 1'b1;
      end
    end
  end

`ifdef SEG7_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (pulse_d && dec_inv_d && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/seg7_capture_decode.md
Name: seg7_capture_decode

Overview:
- Reverse path of the seven-segment encoder. Samples an 8-bit active-low segment bus and decodes it back to a BCD digit, decimal-point, blank and invalid flags.
- A stability filter commits a pattern only after STABLE_CYCLES consecutive identical qualified samples. This rejects multiplex ghosting and glitches.
- Used as a self-check monitor on the 24-hour clock display path and as a front end for the verification scoreboard.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical qualified samples required to commit (legal range 1..255).
- ERR_W, 8, width of the invalid-pattern counter (only used with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seg_in  in  8  segment bus, active-low: bit7 = ~dot, bits6:0 = segments g..a (0 = lit)
- sample_en  in  1  qualifies seg_in on this clock (e.g. digit-select strobe active)
- bcd_out  out  4  committed digit 0..9; 4'hF when blank; 4'hE when invalid
- dot_out  out  1  committed decimal point, active-high (= ~seg_in[7] of the committed pattern)
- blank_out  out  1  committed pattern has all segments 6:0 off
- invalid_out  out  1  committed pattern is neither a digit code nor blank
- update_pulse  out  1  one-cycle strobe when the committed pattern changes
- locked  out  1  high while the current candidate is committed
- err_count  out  ERR_W  saturating count of invalid commits (only with SEG7_ERR_CNT_EN)

Behaviour:
- Decode table for seg_in[6:0] (g..a, active-low):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4
  - 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9
  - 1111111 = blank
  - all other codes = invalid
- Bit 7 never affects digit or validity classification, but it is part of the pattern compared for stability.
- Reset: all outputs and internal state are registered and take these values while reset is high. Reset has priority over sample_en.
  - bcd_out=4'hF, blank_out=1, dot_out=0, invalid_out=0, update_pulse=0, locked=0, err_count=0
  - state=IDLE, cand=8'hFF, cnt=0, last_committed marked "none"
- States:
  - IDLE: no candidate yet.
  - SETTLE: candidate captured, counting.
  - LOCKED: candidate committed.
- Only cycles with sample_en=1 advance the block. With sample_en=0, state, cnt, cand and outputs hold; update_pulse=0.
- Qualified sample in IDLE, or seg_in != cand:
  - cand<=seg_in, cnt<=1, locked<=0, next state SETTLE.
  - If STABLE_CYCLES==1, commit on this same edge and go to LOCKED.
- Qualified sample in SETTLE with seg_in == cand:
  - cnt<=cnt+1.
  - When cnt+1 == STABLE_CYCLES, commit on this edge and go to LOCKED.
- Qualified sample in LOCKED with seg_in == cand: hold; cnt saturates and does not wrap.
- Commit actions:
  - Load bcd_out, dot_out, blank_out and invalid_out from the decode of cand.
  - Set locked=1.
  - update_pulse=1 for exactly one cycle if cand differs from last_committed, or if this is the first commit after reset. last_committed<=cand.
  - Re-committing an identical pattern after a glitch raises no pulse.
- Latency: with seg_in constant and sample_en high from edge k, outputs change at edge k+STABLE_CYCLES-1.
- A changed pattern during SETTLE restarts the count. Previously committed outputs are held, but locked drops on that edge.
- cnt width = clog2(STABLE_CYCLES+1). No arithmetic overflow is possible.
- Reset asserted mid-settle discards the candidate. The next commit after reset always pulses.

Optional Feature:
- Macro: SEG7_ERR_CNT_EN.
- Defined:
  - err_count port and counter are present.
  - The counter increments by 1 on every commit with update_pulse=1 and invalid_out=1.
  - It saturates at all-ones and clears only on reset.
- Undefined: no err_count port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then sample_en=1, seg_in=8'hC0 for 4 clocks (STABLE_CYCLES=4) -> on the 4th edge: bcd_out=0, dot_out=0, locked=1, update_pulse=1 for one cycle; before that: bcd_out=F, blank_out=1, locked=0.
- After locking 8'hC0, apply 8'h24 for 2 clocks then 8'hC0 for 4 clocks -> locked drops at the glitch; bcd_out stays 0 throughout; relock with update_pulse never asserted.
- seg_in=8'h12 with sample_en toggling 1,0,1,0,... -> commit only after 4 qualified edges (7 clocks); bcd_out=5, dot_out=1.
- seg_in=8'hFF stable -> blank_out=1, bcd_out=F, invalid_out=0. Then seg_in=8'hFE stable -> invalid_out=1, bcd_out=E, update_pulse once, err_count=1 (macro defined).
- Assert reset on the 3rd cycle of a 4-cycle settle of 8'h79 -> outputs return to reset values. After release, 4 samples of 8'h79 -> bcd_out=1 with update_pulse.
- With ERR_W=2: commit 4 distinct invalid patterns -> err_count saturates at 3.
